red_pitaya_na_sweep_ctrl: RTL

Bus-master sequencer that runs a network-analyzer frequency sweep on one IQ block.
- Per point: writes the IQ demodulation frequency register, which re-arms averaging, then polls the averaging flag and reads back the 62-bit I/Q sums.
- Delivers each point's result over a valid/ready stream.
- Sits between the PS register bank (sweep settings) and the IQ block's 16-bit-address register port, so sweeps run without per-point PS traffic.

---
 rtl/red_pitaya_na_sweep_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_na_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// red_pitaya_na_sweep_ctrl : network-analyzer sweep sequencer for one IQ block
// Rev 1.0
// ============================================================================
module red_pitaya_na_sweep_ctrl #(
  parameter int          PHASEBITS   = 32,
  parameter int          POINTBITS   = 16,
  parameter int          SUMBITS     = 62,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [15:0] FREQ_ADDR   = 16'h108,
  parameter logic [15:0] SUM_BASE    = 16'h140
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PHASEBITS-1:0] freq_start,
  input  logic [PHASEBITS-1:0] freq_step,
  input  logic [POINTBITS-1:0] n_points,
  output logic [15:0]          m_addr,
  output logic                 m_wen,
  output logic                 m_ren,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_ack,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SUMBITS-1:0]   res_i,
  output logic [SUMBITS-1:0]   res_q,
  output logic [POINTBITS-1:0] res_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int HALF = SUMBITS / 2;
  localparam int TW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_FREQ, S_POLL, S_RD_ILO, S_RD_IHI, S_RD_QLO, S_RD_QHI, S_EMIT
  } state_t;

  state_t                 state_q, state_d;
  logic [PHASEBITS-1:0]   freq_q;
  logic [POINTBITS-1:0]   idx_q;
  logic [TW-1:0]          tmo_q;
  logic [HALF-1:0]        ilo_q, ihi_q, qlo_q;
  logic                   issue_d;
  logic [15:0]            addr_d;
  logic                   bus_st, ack_ok, tmo_hit, last_pt, xfer;

  // Acks are only honoured from the cycle after the strobe onward.
  always_comb begin
    bus_st  = state_q inside {S_WR_FREQ, S_POLL, S_RD_ILO, S_RD_IHI, S_RD_QLO, S_RD_QHI};
    ack_ok  = bus_st && !(m_wen || m_ren) && m_ack;
    tmo_hit = bus_st && !(m_wen || m_ren) && !m_ack && (tmo_q == TMO_LAST);
    last_pt = (idx_q == n_points - POINTBITS'(1));
    xfer    = (state_q == S_EMIT) && res_valid && res_ready;
    state_d = state_q;
    issue_d = 1'b0;
    case (state_q)
      S_IDLE:    if (start && (n_points != '0)) begin state_d = S_WR_FREQ; issue_d = 1'b1; end
      S_WR_FREQ: if (ack_ok) begin state_d = S_POLL; issue_d = 1'b1; end
      S_POLL:    if (ack_ok) begin state_d = m_rdata[31] ? S_POLL : S_RD_ILO; issue_d = 1'b1; end
      S_RD_ILO:  if (ack_ok) begin state_d = S_RD_IHI; issue_d = 1'b1; end
      S_RD_IHI:  if (ack_ok) begin state_d = S_RD_QLO; issue_d = 1'b1; end
      S_RD_QLO:  if (ack_ok) begin state_d = S_RD_QHI; issue_d = 1'b1; end
      S_RD_QHI:  if (ack_ok) state_d = S_EMIT;
      S_EMIT:    if (xfer) begin
                   state_d = last_pt ? S_IDLE : S_WR_FREQ;
                   issue_d = !last_pt;
                 end
      default:   state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
    if (abort) begin
      state_d = S_IDLE;
      issue_d = 1'b0;
    end
    case (state_d)
      S_WR_FREQ: addr_d = FREQ_ADDR;
      S_RD_IHI:  addr_d = SUM_BASE + 16'h4;
      S_RD_QLO:  addr_d = SUM_BASE + 16'h8;
      S_RD_QHI:  addr_d = SUM_BASE + 16'hC;
      default:   addr_d = SUM_BASE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      freq_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      ilo_q     <= '0;
      ihi_q     <= '0;
      qlo_q     <= '0;
      m_addr    <= '0;
      m_wen     <= 1'b0;
      m_ren     <= 1'b0;
      m_wdata   <= '0;
      res_valid <= 1'b0;
      res_i     <= '0;
      res_q     <= '0;
      res_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      m_wen   <= issue_d && (state_d == S_WR_FREQ);
      m_ren   <= issue_d && (state_d != S_WR_FREQ);
      if (issue_d) begin
        m_addr <= addr_d;
        tmo_q  <= '0;
      end else if (bus_st) begin
        tmo_q  <= tmo_q + TW'(1);
      end
      if (abort) begin
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            if (n_points == '0) begin
              done <= 1'b1;
            end else begin
              freq_q  <= freq_start;
              idx_q   <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              m_wdata <= 32'(freq_start);
            end
          end
          S_RD_ILO: if (ack_ok) ilo_q <= m_rdata[HALF-1:0];
          S_RD_IHI: if (ack_ok) ihi_q <= m_rdata[HALF-1:0];
          S_RD_QLO: if (ack_ok) qlo_q <= m_rdata[HALF-1:0];
          S_RD_QHI: if (ack_ok) begin
            res_i     <= {ihi_q, ilo_q};
            res_q     <= {m_rdata[HALF-1:0], qlo_q};
            res_idx   <= idx_q;
            res_valid <= 1'b1;
          end
          S_EMIT: if (xfer) begin
            res_valid <= 1'b0;
            if (last_pt) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              freq_q  <= freq_q + freq_step;
              idx_q   <= idx_q + POINTBITS'(1);
              m_wdata <= 32'(freq_q + freq_step);
            end
          end
          default: ;
        endcase
        if (tmo_hit) begin
          err  <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
